// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a word-wide, byte-addressed data
// memory port. It accepts one load/store at a time, holds the memory strobe
// for WAIT_CYCLES+1 cycles, extracts and extends load lanes, and performs a
// read-modify-write for byte/halfword stores.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned requests.
// With the trap, the request answers with resp_error_o=1 and issues no
// strobes. Without it, the offending low address bits are forced to zero.
module mem_access_unit #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clock_i,
    input  logic        Reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // Count value reached on the final cycle of every strobe window.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    // Registered state and latched request fields.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    size_t       size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;
    logic [29:0] addr_q, addr_d;

    // Registered outputs.
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] data_q, data_d;

    // Request decode: size 11 behaves as a word, and the lane is the
    // effective byte offset after dropping bits that would misalign it.
    size_t      req_size_n;
    logic [1:0] req_lane_n;
    logic       accept;

    assign req_size_n = (req_size_i == 2'b11) ? SZ_WORD : size_t'(req_size_i);
    assign accept     = req_valid_i && ready_q;

    // Effective byte lane of the incoming request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_lane_n = 2'b00;
        case (req_size_n)
            SZ_BYTE: req_lane_n = req_addr_i[1:0];
            SZ_HALF: req_lane_n = {req_addr_i[1], 1'b0};
            default: req_lane_n = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_size_n == SZ_HALF) && req_addr_i[0]) ||
                        ((req_size_n == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`endif

    // Select the addressed lane of a read word and zero/sign-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input size_t       size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the target byte/half lane of a read word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input size_t       size,
                                                input logic [1:0]  lane,
                                                input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{lane, 3'b000} +: 8] = wd[7:0];
            SZ_HALF: begin
                if (lane[1]) r[31:16] = wd;
                else         r[15:0]  = wd;
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic; outputs are computed for the
    // state being entered so that they come straight out of flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        data_d       = data_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_error_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d   = req_size_n;
                    signed_d = req_signed_i;
                    lane_d   = req_lane_n;
                    wdata_d  = req_wdata_i[15:0];
                    addr_d   = req_addr_i[31:2];
                    cnt_d    = 4'd0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else
`endif
                    if (!req_write_i) begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                    end else if (req_size_n == SZ_WORD) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        data_d      = req_wdata_i;
                    end else begin
                        state_d    = RMW_RD;
                        mem_read_d = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end

            RD: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extract(data_i, size_q, lane_q, signed_q);
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    mem_read_d = 1'b1;
                end
            end

            RMW_RD: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d     = RMW_WR;
                    cnt_d       = 4'd0;
                    mem_write_d = 1'b1;
                    data_d      = store_merge(data_i, size_q, lane_q, wdata_q);
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    mem_read_d = 1'b1;
                end
            end

            WR, RMW_WR: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    mem_write_d = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!Reset_n_i) begin
            // NOTE: datapath registers are reset too; they drive outputs that must read 0 in reset.
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            addr_q       <= 30'h0;
            data_q       <= 32'h0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_error_o = resp_error_q;
    assign MemRead_o    = mem_read_q;
    assign MemWrite_o   = mem_write_q;
    assign addr_o       = {addr_q, 2'b00};
    assign data_o       = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit (WAIT_CYCLES=1): directed requests push
// expected responses into a queue; a negedge monitor pops and compares them
// against each resp_valid_o pulse, including latency and strobe counts.
// Expectations for misaligned accesses follow MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit #(.WAIT_CYCLES(1)) dut (
        .Clock_i      (clk),
        .Reset_n_i    (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_error_o (resp_error),
        .MemRead_o    (mem_read),
        .MemWrite_o   (mem_write),
        .addr_o       (mem_addr),
        .data_o       (mem_wdata),
        .data_i       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: 16 words, combinational read, write on strobed edges,
    // plus a backdoor preload port used only while the DUT is idle.
    logic [31:0] mem [0:15];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_data = 32'h0;

    always @(posedge clk) begin
        if (pre_we)         mem[pre_idx] <= pre_data;
        else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[5:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_hist[$];
    int   resp_hist[$];
    int   wr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: strobe sanity each cycle, scoreboard compare on each response.
    int acc_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit in_flight = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_flight = 1'b0;
        end else begin
            if (mem_read || mem_write) check("strobe_exclusive", 32'(mem_read & mem_write), 32'h0);
            if (mem_write) wr_seen++;
            if (in_flight) check("ready_low_busy", 32'(req_ready), 32'h0);
            if (req_valid && req_ready) begin
                acc_cyc   = cyc;
                rd_cnt    = 0;
                wr_cnt    = 0;
                in_flight = 1'b1;
                acc_hist.push_back(cyc);
            end
            if (mem_read) begin
                rd_cnt++;
                if (expq.size() > 0) check("rd_addr", mem_addr, expq[0].addr);
            end
            if (mem_write) begin
                wr_cnt++;
                if (expq.size() > 0) begin
                    check("wr_addr", mem_addr, expq[0].addr);
                    check("wr_data", mem_wdata, expq[0].wdata);
                end
            end
            if (resp_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %h err %b with nothing outstanding",
                             resp_rdata, resp_error);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_error", 32'(resp_error), 32'(e.err));
                    check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    check("read_cycles", 32'(rd_cnt), 32'(e.n_rd));
                    check("write_cycles", 32'(wr_cnt), 32'(e.n_wr));
                end
                resp_hist.push_back(cyc);
                in_flight = 1'b0;
            end
        end
    end

    task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat,
                               input int n_rd, input int n_wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat;
        e.n_rd = n_rd; e.n_wr = n_wr; e.addr = addr; e.wdata = wdata;
        expq.push_back(e);
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
    endtask

    // Wait for the handshake; returns just after the accepting edge.
    task automatic wait_accept();
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
                if (n >= 50) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: req_ready stayed %b for %0d cycles", req_ready, n);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        drive(wr, sz, sg, a, wd);
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (expq.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: %0d responses still outstanding", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] d);
        pre_idx  = idx;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("reset_resp", {30'h0, resp_valid, resp_error}, 32'h0);
        check("reset_data", mem_wdata | mem_addr | resp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;

        // Word store then word load at 0x8.
        expect_resp(32'h0, 1'b0, 3, 0, 2, 32'h8, 32'hDEADBEEF);
        send(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
        wait_done();
        check("mem_after_word_store", mem[2], 32'hDEADBEEF);
        expect_resp(32'hDEADBEEF, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        wait_done();

        // Byte store read-modify-write.
        preload(4'd2, 32'h11223344);
        expect_resp(32'h0, 1'b0, 5, 2, 2, 32'h8, 32'h1122A544);
        send(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000A5);
        wait_done();
        check("mem_after_byte_store", mem[2], 32'h1122A544);

        // Load extraction from 0x80FF7F00.
        preload(4'd2, 32'h80FF7F00);
        expect_resp(32'hFFFFFFFF, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b00, 1'b1, 32'hA, 32'h0);
        expect_resp(32'h000000FF, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b00, 1'b0, 32'hA, 32'h0);
        expect_resp(32'hFFFF80FF, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
        expect_resp(32'h00007F00, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
        expect_resp(32'h0000007F, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        wait_done();

        // Half store into the upper lane; size 11 load behaves as a word.
        expect_resp(32'h0, 1'b0, 5, 2, 2, 32'h8, 32'hBEEF7F00);
        send(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234BEEF);
        wait_done();
        check("mem_after_half_store", mem[2], 32'hBEEF7F00);
        expect_resp(32'hBEEF7F00, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        send(1'b0, 2'b11, 1'b1, 32'h8, 32'h0);
        wait_done();

        // Misaligned word load at 0x6.
        preload(4'd1, 32'hCAFEF00D);
`ifdef MISALIGN_TRAP_EN
        expect_resp(32'h0, 1'b1, 1, 0, 0, 32'h4, 32'h0);
`else
        expect_resp(32'hCAFEF00D, 1'b0, 3, 2, 0, 32'h4, 32'h0);
`endif
        send(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        wait_done();

        // Reset during RMW_RD of a byte store.
        preload(4'd3, 32'h55667788);
        base = wr_seen;
        send(1'b1, 2'b00, 1'b0, 32'hD, 32'h00000012);
        n = 0;
        @(negedge clk);
        while (!mem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_saw_read", 32'(mem_read), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes_drop", {30'h0, mem_read, mem_write}, 32'h0);
        check("abort_ready_low", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after_release", 32'(req_ready), 32'h1);
        repeat (8) @(negedge clk);
        check("abort_no_write", 32'(wr_seen - base), 32'h0);
        check("abort_mem_unchanged", mem[3], 32'h55667788);
        @(posedge clk);
        #1;

        // Two loads queued back to back with req_valid held high.
        acc_hist.delete();
        resp_hist.delete();
        expect_resp(32'hBEEF7F00, 1'b0, 3, 2, 0, 32'h8, 32'h0);
        expect_resp(32'h00000055, 1'b0, 3, 2, 0, 32'hC, 32'h0);
        drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        wait_accept();
        drive(1'b0, 2'b00, 1'b0, 32'hF, 32'h0);
        wait_accept();
        req_valid = 1'b0;
        wait_done();
        if (acc_hist.size() >= 2 && resp_hist.size() >= 1)
            check("b2b_second_accept", 32'(acc_hist[1]), 32'(resp_hist[0] + 1));
        else
            check("b2b_counts", 32'(acc_hist.size()), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
